// File: rtl/systolic_pkg.sv
// Shared sizing and state encoding for the 2x2 systolic array blocks
// (result writer and loaders).
package systolic_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int N_OUT  = 4;
    localparam int IDX_W  = $clog2(N_OUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Negative two's-complement results become zero when enabled; never saturates.
    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] value,
                                               input logic               enable);
        return (enable && value[DATA_W-1]) ? '0 : value;
    endfunction

endpackage

// File: rtl/result_snapshot_buf.sv
// Four-entry result register file: parallel load with ReLU applied on the way in,
// combinational read by index.
module result_snapshot_buf
    import systolic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              relu_en,
    input  logic [DATA_W-1:0] c11,
    input  logic [DATA_W-1:0] c12,
    input  logic [DATA_W-1:0] c21,
    input  logic [DATA_W-1:0] c22,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [N_OUT];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_OUT; i++) begin
                mem[i] <= '0;
            end
        end else if (load) begin
            mem[0] <= relu(c11, relu_en);
            mem[1] <= relu(c12, relu_en);
            mem[2] <= relu(c21, relu_en);
            mem[3] <= relu(c22, relu_en);
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/systolic_result_writer.sv
// Drains the four systolic results into the shared RAM, one registered write
// per cycle starting at a latched base address, with a sticky address-wrap flag.
module systolic_result_writer
    import systolic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] result_baseaddr,
    input  logic              relu_en,
    input  logic [DATA_W-1:0] c11,
    input  logic [DATA_W-1:0] c12,
    input  logic [DATA_W-1:0] c21,
    input  logic [DATA_W-1:0] c22,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    output logic              busy,
    output logic              done,
    output logic              wrap_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d, idx_next;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   ram_addr_d;
    logic [DATA_W-1:0]   ram_data_d;
    logic                ram_we_d, busy_d, done_d, wrap_d;
    logic                snapshot_load;
    logic [DATA_W-1:0]   buf_data;
    logic [ADDR_W:0]     addr_sum;

    result_snapshot_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (snapshot_load),
        .relu_en (relu_en),
        .c11     (c11),
        .c12     (c12),
        .c21     (c21),
        .c22     (c22),
        .rd_idx  (idx_next),
        .rd_data (buf_data)
    );

    assign idx_next = idx_q + 1'b1;
    assign addr_sum = {1'b0, base_q} + {{(ADDR_W + 1 - IDX_W){1'b0}}, idx_next};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            base_q   <= '0;
            ram_addr <= '0;
            ram_data <= '0;
            ram_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wrap_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            base_q   <= base_d;
            ram_addr <= ram_addr_d;
            ram_data <= ram_data_d;
            ram_we   <= ram_we_d;
            busy     <= busy_d;
            done     <= done_d;
            wrap_o   <= wrap_d;
        end
    end

    // Write 0 is registered at the accepting edge itself, so its data bypasses
    // the buffer; later writes read the entry the index is about to advance to.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        base_d        = base_q;
        ram_addr_d    = '0;
        ram_data_d    = '0;
        ram_we_d      = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        wrap_d        = wrap_o;
        snapshot_load = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d       = WRITE;
                    idx_d         = '0;
                    base_d        = result_baseaddr;
                    ram_we_d      = 1'b1;
                    ram_addr_d    = result_baseaddr;
                    ram_data_d    = relu(c11, relu_en);
                    busy_d        = 1'b1;
                    wrap_d        = 1'b0;
                    snapshot_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d      = idx_next;
                    ram_we_d   = 1'b1;
                    ram_addr_d = addr_sum[ADDR_W-1:0];
                    ram_data_d = buf_data;
                    busy_d     = 1'b1;
                    if (addr_sum[ADDR_W]) begin
                        wrap_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_systolic_result_writer.sv
// Directed self-checking bench for systolic_result_writer; each observation is the
// packed vector {ram_we, busy, done, wrap_o, ram_addr, ram_data}.
module tb_systolic_result_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] result_baseaddr;
    logic       relu_en;
    logic [7:0] c11, c12, c21, c22;
    logic [5:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we, busy, done, wrap_o;
    logic [17:0] obs;

    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    assign obs = {ram_we, busy, done, wrap_o, ram_addr, ram_data};

    systolic_result_writer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .result_baseaddr (result_baseaddr),
        .relu_en         (relu_en),
        .c11             (c11),
        .c12             (c12),
        .c21             (c21),
        .c22             (c22),
        .ram_addr        (ram_addr),
        .ram_data        (ram_data),
        .ram_we          (ram_we),
        .busy            (busy),
        .done            (done),
        .wrap_o          (wrap_o)
    );

    task automatic set_inputs(input logic [5:0] base, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d, input logic relu);
        result_baseaddr = base;
        c11 = a;
        c12 = b;
        c21 = c;
        c22 = d;
        relu_en = relu;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        set_inputs(6'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        assertions++;
        if (obs !== 18'h0) begin
            failures++;
            $display("[TB] FAIL reset_state: got %h expected %h", obs, 18'h0);
        end
        rst = 1'b1;
        @(negedge clk);
        assertions++;
        if (obs !== 18'h0) begin
            failures++;
            $display("[TB] FAIL idle_after_release: got %h expected %h", obs, 18'h0);
        end
    endtask

    task automatic test_basic_relu();
        logic [7:0]  exp_d [2][4];
        logic [17:0] expv;
        exp_d[0] = '{8'h05, 8'hFA, 8'h7F, 8'h80};
        exp_d[1] = '{8'h05, 8'h00, 8'h7F, 8'h00};
        for (int r = 0; r < 2; r++) begin
            set_inputs(6'h10, 8'h05, 8'hFA, 8'h7F, 8'h80, r[0]);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 4; i++) begin
                expv = {4'b1100, 6'h10 + 6'(i), exp_d[r][i]};
                assertions++;
                if (obs !== expv) begin
                    failures++;
                    $display("[TB] FAIL basic_write relu=%0d i=%0d: got %h expected %h", r, i, obs, expv);
                end
                @(negedge clk);
            end
            assertions++;
            if (obs !== {4'b0010, 14'h0}) begin
                failures++;
                $display("[TB] FAIL basic_done relu=%0d: got %h expected %h", r, obs, {4'b0010, 14'h0});
            end
            @(negedge clk);
            assertions++;
            if (obs !== 18'h0) begin
                failures++;
                $display("[TB] FAIL basic_idle relu=%0d: got %h expected %h", r, obs, 18'h0);
            end
        end
    endtask

    task automatic test_wrap();
        logic [17:0] expv [5];
        expv[0] = {4'b1100, 6'h3E, 8'h11};
        expv[1] = {4'b1100, 6'h3F, 8'h22};
        expv[2] = {4'b1101, 6'h00, 8'h33};
        expv[3] = {4'b1101, 6'h01, 8'h44};
        expv[4] = {4'b0011, 14'h0};
        set_inputs(6'h3E, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            assertions++;
            if (obs !== expv[i]) begin
                failures++;
                $display("[TB] FAIL wrap_cycle%0d: got %h expected %h", i + 1, obs, expv[i]);
            end
            @(negedge clk);
        end
        repeat (2) begin
            assertions++;
            if (obs !== {4'b0001, 14'h0}) begin
                failures++;
                $display("[TB] FAIL wrap_sticky: got %h expected %h", obs, {4'b0001, 14'h0});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] expv [10];
        expv[0] = {4'b1100, 6'h20, 8'h01};
        expv[1] = {4'b1100, 6'h21, 8'h02};
        expv[2] = {4'b1100, 6'h22, 8'h03};
        expv[3] = {4'b1100, 6'h23, 8'h04};
        expv[4] = {4'b0010, 14'h0};
        expv[5] = {4'b1100, 6'h30, 8'h0A};
        expv[6] = {4'b1100, 6'h31, 8'h0B};
        expv[7] = {4'b1100, 6'h32, 8'h0C};
        expv[8] = {4'b1100, 6'h33, 8'h0D};
        expv[9] = {4'b0010, 14'h0};
        set_inputs(6'h20, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
        start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            assertions++;
            if (obs !== expv[cyc-1]) begin
                failures++;
                $display("[TB] FAIL b2b_cycle%0d: got %h expected %h", cyc, obs, expv[cyc-1]);
            end
            case (cyc)
                1: start = 1'b0;
                2: begin
                    start = 1'b1;
                    set_inputs(6'h00, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 1'b1);
                end
                3: start = 1'b0;
                5: begin
                    start = 1'b1;
                    set_inputs(6'h30, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 1'b0);
                end
                6: begin
                    start = 1'b0;
                    set_inputs(6'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1);
                end
                default: ;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic test_snapshot();
        logic [7:0]  exp_d [4];
        logic [17:0] expv;
        exp_d = '{8'h12, 8'h34, 8'h56, 8'h78};
        set_inputs(6'h08, 8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        set_inputs(6'h00, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            expv = {4'b1100, 6'h08 + 6'(i), exp_d[i]};
            assertions++;
            if (obs !== expv) begin
                failures++;
                $display("[TB] FAIL snapshot_write i=%0d: got %h expected %h", i, obs, expv);
            end
            @(negedge clk);
        end
        assertions++;
        if (obs !== {4'b0010, 14'h0}) begin
            failures++;
            $display("[TB] FAIL snapshot_done: got %h expected %h", obs, {4'b0010, 14'h0});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [17:0] expv;
        set_inputs(6'h04, 8'h21, 8'h22, 8'h23, 8'h24, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        assertions++;
        if (obs !== {4'b1100, 6'h04, 8'h21}) begin
            failures++;
            $display("[TB] FAIL mid_write0: got %h expected %h", obs, {4'b1100, 6'h04, 8'h21});
        end
        @(negedge clk);
        assertions++;
        if (obs !== {4'b1100, 6'h05, 8'h22}) begin
            failures++;
            $display("[TB] FAIL mid_write1: got %h expected %h", obs, {4'b1100, 6'h05, 8'h22});
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        assertions++;
        if (obs !== 18'h0) begin
            failures++;
            $display("[TB] FAIL mid_reset_abort: got %h expected %h", obs, 18'h0);
        end
        @(negedge clk);
        assertions++;
        if (obs !== 18'h0) begin
            failures++;
            $display("[TB] FAIL mid_no_done: got %h expected %h", obs, 18'h0);
        end
        set_inputs(6'h04, 8'h31, 8'h32, 8'h33, 8'h34, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expv = {4'b1100, 6'h04 + 6'(i), 8'h31 + 8'(i)};
            assertions++;
            if (obs !== expv) begin
                failures++;
                $display("[TB] FAIL restart_write i=%0d: got %h expected %h", i, obs, expv);
            end
            @(negedge clk);
        end
        assertions++;
        if (obs !== {4'b0010, 14'h0}) begin
            failures++;
            $display("[TB] FAIL restart_done: got %h expected %h", obs, {4'b0010, 14'h0});
        end
        @(negedge clk);
        start = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        assertions++;
        if (obs !== 18'h0) begin
            failures++;
            $display("[TB] FAIL reset_beats_start: got %h expected %h", obs, 18'h0);
        end
        @(negedge clk);
        assertions++;
        if (obs !== 18'h0) begin
            failures++;
            $display("[TB] FAIL idle_after_coincident: got %h expected %h", obs, 18'h0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_relu();
        test_wrap();
        test_back_to_back();
        test_snapshot();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
